// File: rtl/div.sv
// ----------------------------------------------------------------------------
// div -- 32-bit signed integer divider (quotient -> LO, remainder -> HI)
//
// A divide is requested with a one-cycle pulse on div_start while the unit
// is idle. The operands are latched on the accepting edge. Their magnitudes
// are divided by a restoring divider that produces one quotient bit per
// cycle over 32 cycles. One more cycle applies sign correction and
// publishes the results. The quotient truncates toward zero, and the
// remainder takes the sign of the dividend.
//
// A zero divisor skips the divider. It produces a one-cycle done+div_zero
// pulse on the next cycle and leaves HI/LO unchanged.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-high reset
//   a          : dividend, two's complement
//   b          : divisor, two's complement
//   div_start  : request pulse, only honoured while idle
//   div_hi_out : remainder of the last completed divide
//   div_lo_out : quotient of the last completed divide
//   busy       : a divide has been accepted and has not yet completed
//   done       : one-cycle completion pulse
//   div_zero   : one-cycle divide-by-zero pulse, coincident with done
// ----------------------------------------------------------------------------
module div (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        div_start,
   output logic [31:0] div_hi_out,
   output logic [31:0] div_lo_out,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2,
      DZ     = 2'd3
   } state_t;

   localparam logic [5:0] LAST_ITER = 6'd31;

   state_t      state_reg, state_next;
   logic [5:0]  count_reg, count_next;

   // Divider working registers. quot_reg starts out holding |a|. Each
   // iteration shifts one dividend bit out of its top and one quotient bit
   // into its bottom, so after 32 iterations it holds the unsigned quotient.
   logic [31:0] divisor_reg, divisor_next;
   logic [31:0] quot_reg, quot_next;
   logic [31:0] rem_reg, rem_next;
   logic        sign_a_reg, sign_a_next;
   logic        sign_b_reg, sign_b_next;

   // Registered outputs
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        div_zero_reg, div_zero_next;

   // Operand magnitudes. |0x80000000| is 0x80000000 as an unsigned value,
   // which is exactly what the unsigned divider needs.
   logic [31:0] abs_a, abs_b;
   assign abs_a = a[31] ? (32'd0 - a) : a;
   assign abs_b = b[31] ? (32'd0 - b) : b;

   // One restoring step. The partial remainder is always below the divisor.
   // The shifted value is therefore below 2*divisor and fits in 33 bits.
   // A borrow out of the 33-bit subtraction (bit 32 set) means the trial
   // failed and the shifted value is kept.
   logic [32:0] shifted_rem;
   logic [32:0] trial;
   logic        trial_ok;
   assign shifted_rem = {rem_reg, quot_reg[31]};
   assign trial       = shifted_rem - {1'b0, divisor_reg};
   assign trial_ok    = ~trial[32];

   // Sign correction of the unsigned results. Negating the quotient also
   // covers 0x80000000 / -1. The signs agree in that case, so there is no
   // negation and the unsigned 0x80000000 passes through unchanged.
   logic [31:0] signed_quot, signed_rem;
   assign signed_quot = (sign_a_reg ^ sign_b_reg) ? (32'd0 - quot_reg) : quot_reg;
   assign signed_rem  = sign_a_reg ? (32'd0 - rem_reg) : rem_reg;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         count_reg    <= 6'd0;
         divisor_reg  <= 32'd0;
         quot_reg     <= 32'd0;
         rem_reg      <= 32'd0;
         sign_a_reg   <= 1'b0;
         sign_b_reg   <= 1'b0;
         hi_reg       <= 32'd0;
         lo_reg       <= 32'd0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         div_zero_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         divisor_reg  <= divisor_next;
         quot_reg     <= quot_next;
         rem_reg      <= rem_next;
         sign_a_reg   <= sign_a_next;
         sign_b_reg   <= sign_b_next;
         hi_reg       <= hi_next;
         lo_reg       <= lo_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         div_zero_reg <= div_zero_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      divisor_next  = divisor_reg;
      quot_next     = quot_reg;
      rem_next      = rem_reg;
      sign_a_next   = sign_a_reg;
      sign_b_next   = sign_b_reg;
      hi_next       = hi_reg;
      lo_next       = lo_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;       // done/div_zero are single-cycle pulses
      div_zero_next = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (div_start) begin
               busy_next    = 1'b1;
               count_next   = 6'd0;
               rem_next     = 32'd0;
               quot_next    = abs_a;
               divisor_next = abs_b;
               sign_a_next  = a[31];
               sign_b_next  = b[31];
               state_next   = (b == 32'd0) ? DZ : RUN;
            end
         end

         RUN: begin
            if (trial_ok) begin
               rem_next  = trial[31:0];
               quot_next = {quot_reg[30:0], 1'b1};
            end else begin
               rem_next  = shifted_rem[31:0];
               quot_next = {quot_reg[30:0], 1'b0};
            end
            count_next = count_reg + 6'd1;
            if (count_reg == LAST_ITER) begin
               state_next = FINISH;
            end
         end

         FINISH: begin
            lo_next    = signed_quot;
            hi_next    = signed_rem;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            count_next = 6'd0;
            state_next = IDLE;
         end

         DZ: begin
            // HI/LO keep the previous results
            busy_next     = 1'b0;
            done_next     = 1'b1;
            div_zero_next = 1'b1;
            state_next    = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign div_hi_out = hi_reg;
   assign div_lo_out = lo_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign div_zero   = div_zero_reg;

endmodule

// File: tb/tb_div.sv
// ----------------------------------------------------------------------------
// tb_div -- self-checking bench for div.
// A behavioural model predicts every output on every cycle. It predicts
// results from 64-bit signed arithmetic and timing from the latency rules.
// Directed scenarios pin the model with literal results.
// ----------------------------------------------------------------------------
module tb_div;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        div_start = 1'b0;
   logic [31:0] div_hi_out, div_lo_out;
   logic        busy, done, div_zero;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   div dut (
      .clk        (clk),
      .reset      (reset),
      .a          (a),
      .b          (b),
      .div_start  (div_start),
      .div_hi_out (div_hi_out),
      .div_lo_out (div_lo_out),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   always #5 clk = ~clk;

   // ---------------- reference arithmetic ----------------
   function automatic logic [31:0] ref_quot(input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      return q[31:0];
   endfunction

   function automatic logic [31:0] ref_rem(input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      r  = sx % sy;
      return r[31:0];
   endfunction

   // ---------------- cycle-level behavioural model ----------------
   // remaining = edges left until completion; 0 means idle.
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
   logic [31:0] p_q = 32'd0, p_r = 32'd0;
   logic        p_dz = 1'b0;
   int          remaining = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi <= 32'd0; m_lo <= 32'd0;
         m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
         remaining <= 0;
      end else begin
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         if (remaining > 0) begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               if (p_dz) m_dz <= 1'b1;
               else begin
                  m_hi <= p_r;
                  m_lo <= p_q;
               end
            end
         end else if (div_start) begin
            m_busy <= 1'b1;
            if (b == 32'd0) begin
               p_dz      <= 1'b1;
               remaining <= 1;
            end else begin
               p_dz      <= 1'b0;
               remaining <= 33;
               p_q       <= ref_quot(a, b);
               p_r       <= ref_rem(a, b);
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         checks += 5;
         if (div_hi_out !== m_hi) begin
            errors++;
            $display("FAIL cyc_hi t=%0t got=%h exp=%h", $time, div_hi_out, m_hi);
         end
         if (div_lo_out !== m_lo) begin
            errors++;
            $display("FAIL cyc_lo t=%0t got=%h exp=%h", $time, div_lo_out, m_lo);
         end
         if (busy !== m_busy) begin
            errors++;
            $display("FAIL cyc_busy t=%0t got=%b exp=%b", $time, busy, m_busy);
         end
         if (done !== m_done) begin
            errors++;
            $display("FAIL cyc_done t=%0t got=%b exp=%b", $time, done, m_done);
         end
         if (div_zero !== m_dz) begin
            errors++;
            $display("FAIL cyc_dz t=%0t got=%b exp=%b", $time, div_zero, m_dz);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      a = av; b = bv; div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
   endtask

   // Called at the negedge of cycle 0; returns the cycle on which done is seen.
   task automatic wait_done(input string name, output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cyc = i;
            break;
         end
      end
      if (cyc < 0) begin
         errors++;
         checks++;
         $display("FAIL %s_timeout got=no_done exp=done_within_40", name);
      end
   endtask

   task automatic run_check(input string name, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] eq, input logic [31:0] er, input int elat);
      int cyc;
      start_op(av, bv);
      wait_done(name, cyc);
      check32({name, "_lat"}, cyc, elat);
      check32({name, "_lo"}, div_lo_out, eq);
      check32({name, "_hi"}, div_hi_out, er);
      $display("op %s a=%h b=%h lo=%h hi=%h dz=%b lat=%0d", name, av, bv, div_lo_out, div_hi_out, div_zero, cyc);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return $urandom_range(0, 40);
         5: return 32'd0 - $urandom_range(1, 40);
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      int done_cnt;

      // Model pins (hand-computed)
      check32("ref_q_100_7", ref_quot(32'd100, 32'd7), 32'd14);
      check32("ref_r_100_7", ref_rem(32'd100, 32'd7), 32'd2);
      check32("ref_q_m7_2", ref_quot(32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      check32("ref_r_m7_2", ref_rem(32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      check32("ref_r_7_m2", ref_rem(32'd7, 32'hFFFF_FFFE), 32'd1);
      check32("ref_q_min_m1", ref_quot(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      check32("rst_hi", div_hi_out, 32'd0);
      check32("rst_lo", div_lo_out, 32'd0);
      check32("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);

      // Basic divide with busy and done shape
      start_op(32'd100, 32'd7);
      check32("busy_c1", {31'd0, busy}, 32'd1);
      wait_done("d100_7", cyc);
      check32("d100_7_lat", cyc, 33);
      check32("d100_7_lo", div_lo_out, 32'd14);
      check32("d100_7_hi", div_hi_out, 32'd2);
      check32("d100_7_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check32("done_1cyc", {31'd0, done}, 32'd0);
      $display("op d100_7 lo=%h hi=%h lat=%0d", div_lo_out, div_hi_out, cyc);

      // Divide by zero keeps the previous results
      start_op(32'd5, 32'd0);
      check32("dz_c0_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check32("dz_flags", {30'd0, done, div_zero}, 32'd3);
      check32("dz_lo", div_lo_out, 32'd14);
      check32("dz_hi", div_hi_out, 32'd2);
      $display("op dz lo=%h hi=%h done=%b dz=%b", div_lo_out, div_hi_out, done, div_zero);

      run_check("m7_2",  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
      run_check("7_m2",  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        33);
      run_check("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       33);
      check32("min_m1_dz", {31'd0, div_zero}, 32'd0);
      run_check("small", 32'hFFFF_FFFD, 32'd10,       32'd0,         32'hFFFF_FFFD, 33);
      run_check("zero_a", 32'd0,        32'd9,        32'd0,         32'd0,        33);

      // Restart attempt in RUN is ignored
      start_op(32'd100, 32'd7);
      repeat (4) @(negedge clk);
      a = 32'd555; b = 32'd3; div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      wait_done("restart", cyc);
      check32("restart_lat", cyc + 5, 33);
      check32("restart_lo", div_lo_out, 32'd14);
      check32("restart_hi", div_hi_out, 32'd2);
      $display("op restart lo=%h hi=%h lat=%0d", div_lo_out, div_hi_out, cyc + 5);

      // Reset in the middle of RUN
      start_op(32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      #2 reset = 1'b1; div_start = 1'b1;
      #1;
      check32("arst_hi", div_hi_out, 32'd0);
      check32("arst_lo", div_lo_out, 32'd0);
      check32("arst_flags", {29'd0, busy, done, div_zero}, 32'd0);
      @(negedge clk);
      reset = 1'b0; div_start = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check32("arst_no_done", done_cnt, 0);
      check32("arst_busy", {31'd0, busy}, 32'd0);
      $display("op reset_abort done_count=%0d", done_cnt);

      // Random traffic, including back-to-back starts on the done cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         div_start = ($urandom_range(0, 3) == 0);
         a = rand_val();
         b = rand_val();
         if (done) $display("op rand lo=%h hi=%h dz=%b", div_lo_out, div_hi_out, div_zero);
      end
      div_start = 1'b0;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
